dsp_sequencer: RTL and testbench

//  Sequences the 2-bit display-select of the adder display mux. On start it

---
 rtl/dsp_sequencer_if.sv | 22 ++
 rtl/dsp_sequencer.sv | 107 ++++++++++
 tb/tb_dsp_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_sequencer_if.sv
// Control/status bundle between the display sequencer and whoever drives it.
// The sequencer takes the slave view; the controlling side takes the master view.
interface dsp_sequencer_if;
    logic       start;
    logic       abort;
    logic       hold;
    logic [1:0] manual_sel;
    logic [1:0] dsp_sel;
    logic       load;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, hold, manual_sel,
        input  dsp_sel, load, busy, done
    );

    modport slave (
        input  start, abort, hold, manual_sel,
        output dsp_sel, load, busy, done
    );
endinterface

// File: rtl/dsp_sequencer.sv
// Steps the adder display mux through opA, opB, sum and carry, holding each
// view for DWELL clocks; the select follows manual_sel while idle.
//
//  state      | meaning
//  -----------+--------------------------------------------------
//  IDLE       | select follows manual_sel, waiting for start
//  SHOW_A     | displaying operand A (sel 11)
//  SHOW_B     | displaying operand B (sel 10)
//  SHOW_SUM   | displaying sum (sel 00)
//  SHOW_CARRY | displaying carry (sel 01); last view of a pass
module dsp_sequencer #(
    parameter int DWELL = 16,
    parameter int CNT_W = 5,
    parameter int LOOP  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dsp_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        SHOW_A,
        SHOW_B,
        SHOW_SUM,
        SHOW_CARRY
    } state_t;

    localparam logic [1:0] SEL_A     = 2'b11;
    localparam logic [1:0] SEL_B     = 2'b10;
    localparam logic [1:0] SEL_SUM   = 2'b00;
    localparam logic [1:0] SEL_CARRY = 2'b01;

    // Dwell timer counts down from DWELL-1; the view ends at terminal count 0.
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.dsp_sel <= SEL_SUM;
            bus.load    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.load <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.dsp_sel <= bus.manual_sel;
                    bus.busy    <= 1'b0;
                    if (bus.start) begin
                        state       <= SHOW_A;
                        cnt         <= CNT_TC;
                        bus.dsp_sel <= SEL_A;
                        bus.load    <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                default: begin
                    // The select is left as-is on abort; manual tracking resumes next edge.
                    if (bus.abort) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                    end else if (!bus.hold) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt <= CNT_TC;
                            case (state)
                                SHOW_A: begin
                                    state       <= SHOW_B;
                                    bus.dsp_sel <= SEL_B;
                                end
                                SHOW_B: begin
                                    state       <= SHOW_SUM;
                                    bus.dsp_sel <= SEL_SUM;
                                end
                                SHOW_SUM: begin
                                    state       <= SHOW_CARRY;
                                    bus.dsp_sel <= SEL_CARRY;
                                end
                                default: begin
                                    if (LOOP != 0) begin
                                        state       <= SHOW_A;
                                        bus.dsp_sel <= SEL_A;
                                        bus.load    <= 1'b1;
                                    end else begin
                                        state    <= IDLE;
                                        cnt      <= '0;
                                        bus.busy <= 1'b0;
                                        bus.done <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer (DWELL=4): one-pass and looping instances
// share stimulus; expected per-edge outputs are queued and popped after each edge.
module tb_dsp_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] manual_sel = 2'b00;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];

    dsp_sequencer_if if0 ();
    dsp_sequencer_if if1 ();

    assign if0.start      = start;
    assign if0.abort      = abort;
    assign if0.hold       = hold;
    assign if0.manual_sel = manual_sel;
    assign if1.start      = start;
    assign if1.abort      = abort;
    assign if1.hold       = hold;
    assign if1.manual_sel = manual_sel;

    dsp_sequencer #(.DWELL(4), .CNT_W(5), .LOOP(0)) dut_once (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    dsp_sequencer #(.DWELL(4), .CNT_W(5), .LOOP(1)) dut_loop (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    wire [4:0] obs0 = {if0.dsp_sel, if0.load, if0.busy, if0.done};
    wire [4:0] obs1 = {if1.dsp_sel, if1.load, if1.busy, if1.done};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input logic [1:0] s, input bit l, input bit b, input bit d);
        exp_q.push_back({s, l, b, d});
    endfunction

    // One full pass with SHOW_B lasting len_b cycles; every other view lasts 4.
    function automatic void push_pass(input int len_b);
        push(2'b11, 1, 1, 0);
        for (int i = 0; i < 3; i++) push(2'b11, 0, 1, 0);
        for (int i = 0; i < len_b; i++) push(2'b10, 0, 1, 0);
        for (int i = 0; i < 4; i++) push(2'b00, 0, 1, 0);
        for (int i = 0; i < 4; i++) push(2'b01, 0, 1, 0);
    endfunction

    task automatic check_now(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic tick(input bit use_loop, input string tag, input int e);
        logic [4:0] expv;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s edge %0d: observed no expectation, expected a queued entry", tag, e);
        end else begin
            expv = exp_q.pop_front();
            checks++;
            assert ((use_loop ? obs1 : obs0) === expv) else begin
                errors++;
                $error("FAIL %s edge %0d: observed %b expected %b", tag, e,
                       (use_loop ? obs1 : obs0), expv);
            end
        end
    endtask

    // Edge 0 always samples start=1; negative indices disable an event.
    task automatic run(input bit use_loop, input string tag, input int n,
                       input int hold_lo, input int hold_hi,
                       input int abort_e, input int start2_e);
        for (int e = 0; e < n; e++) begin
            start = (e == 0) || (e == start2_e);
            hold  = (e >= hold_lo) && (e <= hold_hi);
            abort = (e == abort_e);
            tick(use_loop, tag, e);
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        manual_sel = 2'b10;
        do_reset();
        #1;
        check_now("reset_once", obs0, 5'b00_0_0_0);
        check_now("reset_loop", obs1, 5'b00_0_0_0);

        push(2'b10, 0, 0, 0);
        tick(0, "idle_manual", 0);

        // Basic pass; dsp_sel returns to manual_sel one edge after done.
        push_pass(4);
        push(2'b01, 0, 0, 1);
        push(2'b10, 0, 0, 0);
        run(0, "basic", 18, -1, -2, -1, -1);

        // hold for three edges in SHOW_B stretches it to 7 cycles.
        push_pass(7);
        push(2'b01, 0, 0, 1);
        push(2'b10, 0, 0, 0);
        run(0, "hold_b", 21, 5, 7, -1, -1);

        // abort in SHOW_SUM at edge 9, then manual tracking.
        manual_sel = 2'b00;
        push(2'b11, 1, 1, 0);
        for (int i = 0; i < 3; i++) push(2'b11, 0, 1, 0);
        for (int i = 0; i < 4; i++) push(2'b10, 0, 1, 0);
        push(2'b00, 0, 1, 0);
        push(2'b00, 0, 0, 0);
        run(0, "abort", 10, -1, -2, 9, -1);
        manual_sel = 2'b11;
        push(2'b11, 0, 0, 0);
        tick(0, "abort_manual", 10);

        // start with abort in IDLE still starts a full pass.
        push_pass(4);
        push(2'b01, 0, 0, 1);
        push(2'b11, 0, 0, 0);
        run(0, "start_abort_idle", 18, -1, -2, 0, -1);

        // start while busy is ignored.
        manual_sel = 2'b10;
        push_pass(4);
        push(2'b01, 0, 0, 1);
        push(2'b10, 0, 0, 0);
        run(0, "start_busy", 18, -1, -2, -1, 5);

        // LOOP=1 wraps carry->opA with load and no done.
        do_reset();
        manual_sel = 2'b11;
        push_pass(4);
        push_pass(4);
        push(2'b11, 1, 1, 0);
        push(2'b11, 0, 0, 0);
        run(1, "loop", 34, -1, -2, 33, -1);

        // Async reset in SHOW_B clears outputs immediately.
        do_reset();
        manual_sel = 2'b10;
        push(2'b11, 1, 1, 0);
        for (int i = 0; i < 3; i++) push(2'b11, 0, 1, 0);
        for (int i = 0; i < 2; i++) push(2'b10, 0, 1, 0);
        run(0, "pre_reset", 6, -1, -2, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst_once", obs0, 5'b00_0_0_0);
        check_now("async_rst_loop", obs1, 5'b00_0_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        push(2'b10, 0, 0, 0);
        tick(0, "post_reset", 0);
        push(2'b10, 0, 0, 0);
        tick(0, "post_reset_no_done", 1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
